// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state/op encodings and counter sizing for muldiv_unit
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: two's-complement conditional negator
module muldiv_negate #(parameter int W = 32) (
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  assign out = en ? -in : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle shift-add multiply / restoring divide producing HI/LO
// Define MULDIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic op_q, zero_q, neg_q, neg_r, sa, sb, ge;
  logic [2*WIDTH-1:0] acc, res_in, res_fix;
  logic [WIDTH-1:0] dvs, a_mag, b_mag, rem_fix, diff;
  logic [WIDTH:0] sum, shl;
`ifdef MULDIV_SIGNED_EN
  assign sa = is_signed & a[WIDTH-1];
  assign sb = is_signed & b[WIDTH-1];
`else
  logic unused_sign;
  assign unused_sign = is_signed;
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  muldiv_negate #(.W(WIDTH)) u_neg_a (.en(sa), .in(a), .out(a_mag));
  muldiv_negate #(.W(WIDTH)) u_neg_b (.en(sb), .in(b), .out(b_mag));
  // quotient is negated through the wide negator with a zero upper half
  assign res_in = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
  muldiv_negate #(.W(2*WIDTH)) u_neg_res (.en(neg_q), .in(res_in), .out(res_fix));
  muldiv_negate #(.W(WIDTH)) u_neg_rem (.en(neg_r), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvs & {WIDTH{acc[0]}}};
  assign shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge   = shl >= {1'b0, dvs};
  // when ge holds the true difference is below the divisor, so W bits suffice
  assign diff = shl[WIDTH-1:0] - dvs;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      dvs      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          op_q   <= op;
          zero_q <= op == OP_DIV && b == '0;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          cnt    <= '0;
          busy   <= 1'b1;
          acc    <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a_mag : b_mag};
          dvs    <= (op == OP_DIV) ? b_mag : a_mag;
          state  <= (op == OP_DIV && b == '0) ? FIX : RUN;
        end
        RUN: begin
          acc <= (op_q == OP_MUL) ? {sum, acc[WIDTH-1:1]}
                                  : {ge ? diff : shl[WIDTH-1:0], acc[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        default: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= zero_q;
          if (!zero_q) begin
            hi <= (op_q == OP_DIV) ? rem_fix : res_fix[2*WIDTH-1:WIDTH];
            lo <= res_fix[WIDTH-1:0];
          end
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SG_EN = 1'b1;
`else
  localparam bit SG_EN = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc;
    int           cyc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, op = 1'b0, is_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on every done and watches busy/idle behaviour
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("reset_busy", {31'b0, busy}, 0);
      chk("reset_done", {31'b0, done}, 0);
      chk("reset_div_zero", {31'b0, div_zero}, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
    end else begin
      chk("busy", {31'b0, busy}, {31'b0, q.size() > 0 && cyc >= q[0].acc && cyc < q[0].cyc});
      if (done) begin
        if (q.size() == 0) chk("spurious_done", {31'b0, done}, 0);
        else begin
          e = q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("div_zero_idle", {31'b0, div_zero}, 0);
        if (q.size() > 0 && cyc >= q[0].cyc) begin
          e = q.pop_front();
          chk("done_timeout", {31'b0, done}, 1);
        end
      end
    end
  end

  // reference model: plain 64-bit arithmetic on the (possibly signed) operands
  task automatic issue(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold2);
    exp_t e;
    longint sx, sy;
    logic [2*W-1:0] p, r;
    sx = (s && SG_EN) ? longint'({{W{x[W-1]}}, x}) : longint'({{W{1'b0}}, x});
    sy = (s && SG_EN) ? longint'({{W{y[W-1]}}, y}) : longint'({{W{1'b0}}, y});
    e.dz  = 1'b0;
    e.acc = cyc + (hold2 ? 2 : 1);
    e.cyc = e.acc + W + 1;
    if (o) begin
      if (y == '0) begin
        e.dz = 1'b1;
        e.hi = last_hi;
        e.lo = last_lo;
        e.cyc = e.acc + 1;
      end else begin
        p = sx / sy;
        r = sx % sy;
        e.lo = p[W-1:0];
        e.hi = r[W-1:0];
      end
    end else begin
      p = sx * sy;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end
    last_hi = e.hi;
    last_lo = e.lo;
    q.push_back(e);
    start = 1'b1; op = o; is_signed = s; a = x; b = y;
    @(negedge clk);
    if (hold2) @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic wait_done(input bit inject);
    for (int i = 1; i < 3 * W && !done; i++) begin
      start = inject && (i == 5 || i == 20);
      if (start) begin a = $urandom; b = $urandom; op = 1'($urandom); is_signed = 1'($urandom); end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // b2b: called while done is showing, so start is held across the ignored done cycle
  task automatic run(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                     input bit b2b, input bit inject);
    if (!b2b) @(negedge clk);
    issue(o, s, x, y, b2b);
    wait_done(inject);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {{(W-1){1'b0}}, 1'b1};
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    run(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(1'b1, 1'b0, 32'd5, 32'd2, 1'b0, 1'b0);
    run(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    run(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
    run(1'b0, 1'b1, 32'hFFFFFFF0, 32'd9, 1'b1, 1'b0);
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      logic o;
      o = 1'($urandom);
      run(o, 1'($urandom), pick(), pick(), $urandom_range(0, 3) == 0, !o && $urandom_range(0, 3) == 0);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit. It is the successor to the CPU's separate fixed-width `mult` and `div` blocks. A single shared datapath produces the HI/LO pair for MULT/MULTU/DIV/DIVU, with an explicit start/busy/done handshake that the control unit polls instead of counting cycles. It sits between the A/B operand registers and the HI/LO register muxes.

## Interface
- `WIDTH`, default 32: operand width. Must be ≥ 4. HI and LO are each `WIDTH` bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation. Sampled only in IDLE.
- `op` in 1: 0 = multiply, 1 = divide. Sampled with `start`.
- `is_signed` in 1: 1 = two's-complement operands. Sampled with `start`.
- `a` in WIDTH: multiplicand / dividend. Sampled with `start`.
- `b` in WIDTH: multiplier / divisor. Sampled with `start`.
- `busy` out 1: high from the edge after `start` is accepted until the edge that raises `done`.
- `done` out 1: single-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `div_zero` out 1: pulses together with `done` when a divide has `b == 0`.
- `hi` out WIDTH: product upper half / remainder.
- `lo` out WIDTH: product lower half / quotient.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
- States: IDLE → RUN → FIX → IDLE.
- IDLE + `start`:
  - Operands are latched. For signed operations, magnitudes are taken and result signs recorded.
  - Iteration counter is cleared and the unit goes to RUN.
- IDLE + `start` + `op`=1 + `b`=0:
  - Goes straight to FIX with the zero flag set.
  - Produces `done`=1, `div_zero`=1.
  - `hi`/`lo` hold their previous values.
- RUN, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- RUN lasts exactly WIDTH cycles, then goes to FIX.
- FIX: applies sign correction and registers `hi`/`lo`. Pulses `done`, drops `busy`, returns to IDLE.
- Signed multiply: the full 2·WIDTH two's-complement product.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/−1 yields `lo`=MIN, `hi`=0. No flag is raised.
- `hi`/`lo` hold their values between `done` pulses.
- `start` while `busy`=1 is ignored and has no side effects.
- `start` in the same cycle as `done` is ignored. The next `start` is accepted from IDLE one cycle later.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values. The pending result is lost.

## Timing
- Start accepted at edge E0. Multiply/divide latency is fixed and independent of operand values:
  - RUN iterations occur at E1..E(WIDTH).
  - FIX at E(WIDTH+1) raises `done`.
  - Total latency is WIDTH+1 cycles; 33 for WIDTH=32.
- Divide-by-zero: `done` and `div_zero` are raised at E1 (latency 1).
- `busy` is high from E0 up to, but not including, the `done` cycle.
- Operands may change after E0; they are not re-sampled.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN` defined: `is_signed` is honoured, and the sign logic and FIX correction are compiled in.
- Not defined:
  - `is_signed` is ignored and every operation is unsigned.
  - The FIX state is kept as a plain register stage, so latency is identical in both builds.

## Structure
- Shared package `muldiv_pkg` holds:
  - State encoding (IDLE, RUN, FIX).
  - Op encoding constants (`OP_MUL`=0, `OP_DIV`=1).
  - Counter width function `$clog2(WIDTH+1)`.
- One sub-module, `muldiv_negate`: a parametrised two's-complement conditional negator (`en`, `in`, `out`). It is used for operand magnitudes and result sign fixup.

## Test plan
- Unsigned multiply, WIDTH=32, `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high throughout.
- Signed multiply, −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Without `MULDIV_SIGNED_EN` the same inputs give `hi`=0x00000006, `lo`=0xFFFFFFEB.
- Signed divide:
  - −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero, `a`=5, `b`=0 after a prior result (`hi`=1, `lo`=2) → `done`=`div_zero`=1 one cycle after start; `hi`=1, `lo`=2 unchanged.
- Pulse `start` with new operands at cycles 5 and 20 of a running multiply → ignored; the original result is delivered on time.
- Reset low at cycle 10 of a divide → `busy`=0, `hi`=`lo`=0 at once; the next 100/7 gives `lo`=14, `hi`=2.
